// File: rtl/ddr_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_axi_pkg
// Description : Shared types and constants for the DDR AXI burst master.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_FINISH  = 3'd6
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         MAX_BEATS   = 256;

    function automatic logic len_is_valid(input logic [8:0] len);
        return (len != 9'd0) && (int'(len) <= MAX_BEATS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_axi_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_axi_burst_master_if
// Description : User command/stream signals plus the DDR slave AXI channels.
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_axi_burst_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic        err;

    logic [3:0]  MASTER_WR_ADDR_ID;
    logic [31:0] MASTER_WR_ADDR;
    logic [7:0]  MASTER_WR_ADDR_LEN;
    logic [1:0]  MASTER_WR_ADDR_BURST;
    logic        MASTER_WR_ADDR_VALID;
    logic        MASTER_WR_ADDR_READY;
    logic [31:0] MASTER_WR_DATA;
    logic [3:0]  MASTER_WR_STRB;
    logic        MASTER_WR_DATA_LAST;
    logic        MASTER_WR_DATA_VALID;
    logic        MASTER_WR_DATA_READY;
    logic [3:0]  MASTER_WR_BACK_ID;
    logic [1:0]  MASTER_WR_BACK_RESP;
    logic        MASTER_WR_BACK_VALID;
    logic        MASTER_WR_BACK_READY;
    logic [3:0]  MASTER_RD_ADDR_ID;
    logic [31:0] MASTER_RD_ADDR;
    logic [7:0]  MASTER_RD_ADDR_LEN;
    logic [1:0]  MASTER_RD_ADDR_BURST;
    logic        MASTER_RD_ADDR_VALID;
    logic        MASTER_RD_ADDR_READY;
    logic [3:0]  MASTER_RD_BACK_ID;
    logic [31:0] MASTER_RD_BACK_DATA;
    logic [1:0]  MASTER_RD_BACK_DATA_RESP;
    logic        MASTER_RD_BACK_DATA_LAST;
    logic        MASTER_RD_DATA_VALID;
    logic        MASTER_RD_DATA_READY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_data, wr_strb, wr_valid, rd_ready,
        output cmd_ready, wr_ready, rd_data, rd_last, rd_valid, done, err,
        output MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN,
        output MASTER_WR_ADDR_BURST, MASTER_WR_ADDR_VALID,
        input  MASTER_WR_ADDR_READY,
        output MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST, MASTER_WR_DATA_VALID,
        input  MASTER_WR_DATA_READY,
        input  MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
        output MASTER_WR_BACK_READY,
        output MASTER_RD_ADDR_ID, MASTER_RD_ADDR, MASTER_RD_ADDR_LEN,
        output MASTER_RD_ADDR_BURST, MASTER_RD_ADDR_VALID,
        input  MASTER_RD_ADDR_READY,
        input  MASTER_RD_BACK_ID, MASTER_RD_BACK_DATA, MASTER_RD_BACK_DATA_RESP,
        input  MASTER_RD_BACK_DATA_LAST, MASTER_RD_DATA_VALID,
        output MASTER_RD_DATA_READY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_data, wr_strb, wr_valid, rd_ready,
        input  cmd_ready, wr_ready, rd_data, rd_last, rd_valid, done, err,
        input  MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN,
        input  MASTER_WR_ADDR_BURST, MASTER_WR_ADDR_VALID,
        output MASTER_WR_ADDR_READY,
        input  MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST, MASTER_WR_DATA_VALID,
        output MASTER_WR_DATA_READY,
        output MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
        input  MASTER_WR_BACK_READY,
        input  MASTER_RD_ADDR_ID, MASTER_RD_ADDR, MASTER_RD_ADDR_LEN,
        input  MASTER_RD_ADDR_BURST, MASTER_RD_ADDR_VALID,
        output MASTER_RD_ADDR_READY,
        output MASTER_RD_BACK_ID, MASTER_RD_BACK_DATA, MASTER_RD_BACK_DATA_RESP,
        output MASTER_RD_BACK_DATA_LAST, MASTER_RD_DATA_VALID,
        input  MASTER_RD_DATA_READY
    );

endinterface
`default_nettype wire

// File: rtl/ddr_axi_wdog.sv
`default_nettype none
// ============================================================================
// Module      : ddr_axi_wdog
// Description : Handshake-progress watchdog; expires after LIMIT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_axi_wdog #(
    parameter int LIMIT = 4096
) (
    input  wire  clk,
    input  wire  rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    // Expiry fires on the LIMIT-th consecutive enabled cycle without a clear.
    assign expire_o = en_i && !clr_i && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : ddr_axi_burst_master
// Description : Turns single user commands into one INCR burst on the DDR port.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_axi_burst_master
    import ddr_axi_pkg::*;
#(
    parameter logic [3:0] ID_VAL      = 4'h0,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         CNT_W       = 9
) (
    input  wire clk,
    input  wire rst,
    ddr_axi_burst_master_if.master bus
);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [7:0]       len_m1_q, len_m1_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             err_q, err_d;

    logic w_in_idle, w_in_wd, w_in_rd, w_in_fin;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs;
    logic w_final, w_expire, w_b_bad, w_r_bad;

    assign w_in_idle = (state_q == ST_IDLE);
    assign w_in_wd   = (state_q == ST_WR_DATA);
    assign w_in_rd   = (state_q == ST_RD_DATA);
    assign w_in_fin  = (state_q == ST_FINISH);

    assign w_aw_hs  = (state_q == ST_WR_ADDR) && bus.MASTER_WR_ADDR_READY;
    assign w_w_hs   = w_in_wd && bus.wr_valid && bus.MASTER_WR_DATA_READY;
    assign w_b_hs   = (state_q == ST_WR_RESP) && bus.MASTER_WR_BACK_VALID;
    assign w_ar_hs  = (state_q == ST_RD_ADDR) && bus.MASTER_RD_ADDR_READY;
    assign w_r_hs   = w_in_rd && bus.MASTER_RD_DATA_VALID && bus.rd_ready;
    assign w_any_hs = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;

    // beat_q counts completed beats, so the final beat is the one at index len-1
    assign w_final = (beat_q == CNT_W'(len_m1_q));
    assign w_b_bad = (bus.MASTER_WR_BACK_RESP != RESP_OKAY) || (bus.MASTER_WR_BACK_ID != ID_VAL);
    assign w_r_bad = (bus.MASTER_RD_BACK_DATA_RESP != RESP_OKAY) || (bus.MASTER_RD_BACK_ID != ID_VAL);

    ddr_axi_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (w_in_idle || w_in_fin || w_any_hs),
        .en_i     (!(w_in_idle || w_in_fin)),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_m1_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_m1_q <= len_m1_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_m1_d = len_m1_q;
        beat_d   = beat_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr & ~32'h3;
                    beat_d = '0;
                    if (len_is_valid(bus.cmd_len)) begin
                        len_m1_d = 8'(bus.cmd_len - 9'd1);
                        err_d    = 1'b0;
                        state_d  = bus.cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_WR_ADDR: if (w_aw_hs) state_d = ST_WR_DATA;
            ST_WR_DATA: begin
                if (w_w_hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (w_final) state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    if (w_b_bad) err_d = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_RD_ADDR: if (w_ar_hs) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (w_r_hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (w_r_bad || (bus.MASTER_RD_BACK_DATA_LAST != w_final)) err_d = 1'b1;
                    if (bus.MASTER_RD_BACK_DATA_LAST || w_final) state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                beat_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Expiry already excludes any handshake cycle, so progress wins a tie.
        if (w_expire) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
        end
    end

    assign bus.cmd_ready = w_in_idle && !rst;
    assign bus.done      = w_in_fin;
    assign bus.err       = w_in_fin && err_q;

    assign bus.MASTER_WR_ADDR_ID    = ID_VAL;
    assign bus.MASTER_WR_ADDR       = addr_q;
    assign bus.MASTER_WR_ADDR_LEN   = len_m1_q;
    assign bus.MASTER_WR_ADDR_BURST = BURST_INCR;
    assign bus.MASTER_WR_ADDR_VALID = (state_q == ST_WR_ADDR);

    assign bus.MASTER_WR_DATA       = w_in_wd ? bus.wr_data : '0;
    assign bus.MASTER_WR_STRB       = w_in_wd ? bus.wr_strb : '0;
    assign bus.MASTER_WR_DATA_LAST  = w_in_wd && w_final;
    assign bus.MASTER_WR_DATA_VALID = w_in_wd && bus.wr_valid;
    assign bus.wr_ready             = w_in_wd && bus.MASTER_WR_DATA_READY;
    assign bus.MASTER_WR_BACK_READY = (state_q == ST_WR_RESP);

    assign bus.MASTER_RD_ADDR_ID    = ID_VAL;
    assign bus.MASTER_RD_ADDR       = addr_q;
    assign bus.MASTER_RD_ADDR_LEN   = len_m1_q;
    assign bus.MASTER_RD_ADDR_BURST = BURST_INCR;
    assign bus.MASTER_RD_ADDR_VALID = (state_q == ST_RD_ADDR);

    assign bus.MASTER_RD_DATA_READY = w_in_rd && bus.rd_ready;
    assign bus.rd_valid             = w_in_rd && bus.MASTER_RD_DATA_VALID;
    assign bus.rd_data              = w_in_rd ? bus.MASTER_RD_BACK_DATA : '0;
    assign bus.rd_last              = w_in_rd && bus.MASTER_RD_BACK_DATA_LAST;

endmodule
`default_nettype wire

// File: tb/tb_ddr_axi_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ddr_axi_burst_master
// Description : Directed self-checking bench for ddr_axi_burst_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_axi_burst_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ddr_axi_burst_master_if bus();

    ddr_axi_burst_master #(
        .ID_VAL      (4'h0),
        .TIMEOUT_CYC (16),
        .CNT_W       (9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic clear_inputs();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_data = '0; bus.wr_strb = '0; bus.wr_valid = 0; bus.rd_ready = 0;
        bus.MASTER_WR_ADDR_READY = 0; bus.MASTER_WR_DATA_READY = 0;
        bus.MASTER_WR_BACK_ID = '0; bus.MASTER_WR_BACK_RESP = '0; bus.MASTER_WR_BACK_VALID = 0;
        bus.MASTER_RD_ADDR_READY = 0; bus.MASTER_RD_BACK_ID = '0; bus.MASTER_RD_BACK_DATA = '0;
        bus.MASTER_RD_BACK_DATA_RESP = '0; bus.MASTER_RD_BACK_DATA_LAST = 0;
        bus.MASTER_RD_DATA_VALID = 0;
    endtask

    task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [8:0] len);
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = len;
        @(negedge clk);
        bus.cmd_valid = 0;
    endtask

    // Write driver: acts as user producer and DDR slave, collects observations.
    task automatic run_write(input logic [31:0] addr, input logic [8:0] len, input bit gaps,
                             input logic [1:0] bresp, input logic [3:0] bid,
                             output int beats, output int bad_last, output int bad_data,
                             output int bad_hold, output bit got_done, output bit got_err,
                             output logic [31:0] aw_addr, output logic [7:0] aw_len);
        bit aw_stall, w_stall;
        logic [31:0] p_addr, p_data;
        logic [7:0]  p_len;
        logic        p_last;
        beats = 0; bad_last = 0; bad_data = 0; bad_hold = 0; got_done = 0; got_err = 0;
        aw_addr = '0; aw_len = '0; aw_stall = 0; w_stall = 0;
        p_addr = '0; p_data = '0; p_len = '0; p_last = 0;
        issue_cmd(1'b1, addr, len);
        for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
            bus.MASTER_WR_ADDR_READY = !gaps || (cyc % 4 != 1);
            bus.MASTER_WR_DATA_READY = !gaps || (cyc % 3 != 1);
            bus.wr_valid = (int'(len) > beats) && (w_stall || !gaps || (cyc % 5 != 2));
            bus.wr_data  = 32'hA0 + 32'(beats);
            bus.wr_strb  = 4'hF;
            bus.MASTER_WR_BACK_VALID = (beats == int'(len));
            bus.MASTER_WR_BACK_RESP  = bresp;
            bus.MASTER_WR_BACK_ID    = bid;
            #1;
            if (bus.done) begin got_done = 1; got_err = bus.err; end
            if (aw_stall && (!bus.MASTER_WR_ADDR_VALID || bus.MASTER_WR_ADDR !== p_addr ||
                             bus.MASTER_WR_ADDR_LEN !== p_len)) bad_hold++;
            if (w_stall && (!bus.MASTER_WR_DATA_VALID || bus.MASTER_WR_DATA !== p_data ||
                            bus.MASTER_WR_DATA_LAST !== p_last)) bad_hold++;
            if (bus.MASTER_WR_ADDR_VALID && bus.MASTER_WR_ADDR_READY) begin
                aw_addr = bus.MASTER_WR_ADDR; aw_len = bus.MASTER_WR_ADDR_LEN;
            end
            if (bus.MASTER_WR_DATA_VALID && bus.MASTER_WR_DATA_READY) begin
                if (bus.MASTER_WR_DATA !== 32'hA0 + 32'(beats)) bad_data++;
                if (bus.MASTER_WR_DATA_LAST !== (beats + 1 == int'(len))) bad_last++;
                beats++;
            end
            aw_stall = bus.MASTER_WR_ADDR_VALID && !bus.MASTER_WR_ADDR_READY;
            w_stall  = bus.MASTER_WR_DATA_VALID && !bus.MASTER_WR_DATA_READY;
            p_addr = bus.MASTER_WR_ADDR; p_len = bus.MASTER_WR_ADDR_LEN;
            p_data = bus.MASTER_WR_DATA; p_last = bus.MASTER_WR_DATA_LAST;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    // Read driver: slave returns d0+k on beat k, LAST on beat last_at, SLVERR on bad_beat.
    task automatic run_read(input logic [31:0] addr, input logic [8:0] len, input int last_at,
                            input int bad_beat, input logic [31:0] d0,
                            output int beats, output int last_beat, output int bad_data,
                            output bit got_done, output bit got_err,
                            output logic [31:0] ar_addr, output logic [7:0] ar_len);
        bit ar_ok;
        beats = 0; last_beat = 0; bad_data = 0; got_done = 0; got_err = 0;
        ar_addr = '0; ar_len = '0; ar_ok = 0;
        issue_cmd(1'b0, addr, len);
        for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
            bus.MASTER_RD_ADDR_READY     = 1;
            bus.MASTER_RD_DATA_VALID     = ar_ok && (beats < last_at);
            bus.MASTER_RD_BACK_DATA      = d0 + 32'(beats);
            bus.MASTER_RD_BACK_DATA_LAST = (beats + 1 == last_at);
            bus.MASTER_RD_BACK_DATA_RESP = (beats + 1 == bad_beat) ? 2'b10 : 2'b00;
            bus.MASTER_RD_BACK_ID        = 4'h0;
            bus.rd_ready                 = 1;
            #1;
            if (bus.done) begin got_done = 1; got_err = bus.err; end
            if (bus.MASTER_RD_ADDR_VALID && bus.MASTER_RD_ADDR_READY) begin
                ar_ok = 1; ar_addr = bus.MASTER_RD_ADDR; ar_len = bus.MASTER_RD_ADDR_LEN;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (bus.rd_data !== d0 + 32'(beats)) bad_data++;
                if (bus.rd_last) last_beat = beats + 1;
                beats++;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.cmd_ready, bus.done, bus.err, bus.MASTER_WR_ADDR_VALID, bus.MASTER_WR_DATA_VALID,
             bus.MASTER_RD_ADDR_VALID, bus.MASTER_RD_DATA_READY, bus.MASTER_WR_BACK_READY} !== 8'h00) begin
            fails++; $display("FAIL reset_outputs: got cmd_ready=%b done=%b awv=%b wv=%b arv=%b, want all 0",
                              bus.cmd_ready, bus.done, bus.MASTER_WR_ADDR_VALID,
                              bus.MASTER_WR_DATA_VALID, bus.MASTER_RD_ADDR_VALID);
        end
        tests++;
        if ({bus.MASTER_WR_ADDR_BURST, bus.MASTER_RD_ADDR_BURST, bus.MASTER_WR_ADDR_ID,
             bus.MASTER_RD_ADDR_ID} !== {2'b01, 2'b01, 4'h0, 4'h0}) begin
            fails++; $display("FAIL reset_burst_id: got wb=%b rb=%b wid=%h rid=%h, want 01 01 0 0",
                              bus.MASTER_WR_ADDR_BURST, bus.MASTER_RD_ADDR_BURST,
                              bus.MASTER_WR_ADDR_ID, bus.MASTER_RD_ADDR_ID);
        end
        rst = 0;
        @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL idle_cmd_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write4();
        int beats, bl, bd, bh; bit d, e; logic [31:0] a; logic [7:0] l;
        run_write(32'h0000_1003, 9'd4, 1'b0, 2'b00, 4'h0, beats, bl, bd, bh, d, e, a, l);
        tests++;
        if (a !== 32'h0000_1000 || l !== 8'd3) begin
            fails++; $display("FAIL wr4_aw: got addr=%h len=%0d want 00001000 3", a, l);
        end
        tests++;
        if (beats !== 4 || bl !== 0 || bd !== 0) begin
            fails++; $display("FAIL wr4_beats: got beats=%0d badlast=%0d baddata=%0d want 4 0 0", beats, bl, bd);
        end
        tests++;
        if (d !== 1'b1 || e !== 1'b0) begin
            fails++; $display("FAIL wr4_done: got done=%b err=%b want 1 0", d, e);
        end
    endtask

    task automatic test_read1();
        int beats, lb, bd; bit d, e; logic [31:0] a; logic [7:0] l;
        run_read(32'h0000_0100, 9'd1, 1, 0, 32'hDEAD_BEEF, beats, lb, bd, d, e, a, l);
        tests++;
        if (a !== 32'h0000_0100 || l !== 8'd0) begin
            fails++; $display("FAIL rd1_ar: got addr=%h len=%0d want 00000100 0", a, l);
        end
        tests++;
        if (beats !== 1 || bd !== 0 || lb !== 1) begin
            fails++; $display("FAIL rd1_data: got beats=%0d baddata=%0d lastbeat=%0d want 1 0 1", beats, bd, lb);
        end
        tests++;
        if (d !== 1'b1 || e !== 1'b0) begin
            fails++; $display("FAIL rd1_done: got done=%b err=%b want 1 0", d, e);
        end
    endtask

    task automatic test_write256_gaps();
        int beats, bl, bd, bh; bit d, e; logic [31:0] a; logic [7:0] l;
        run_write(32'h0001_0000, 9'd256, 1'b1, 2'b00, 4'h0, beats, bl, bd, bh, d, e, a, l);
        tests++;
        if (l !== 8'd255 || a !== 32'h0001_0000) begin
            fails++; $display("FAIL wr256_aw: got addr=%h len=%0d want 00010000 255", a, l);
        end
        tests++;
        if (beats !== 256 || bl !== 0 || bd !== 0) begin
            fails++; $display("FAIL wr256_beats: got beats=%0d badlast=%0d baddata=%0d want 256 0 0", beats, bl, bd);
        end
        tests++;
        if (bh !== 0) begin
            fails++; $display("FAIL wr256_hold: got %0d payload changes while stalled want 0", bh);
        end
        tests++;
        if (d !== 1'b1 || e !== 1'b0) begin
            fails++; $display("FAIL wr256_done: got done=%b err=%b want 1 0", d, e);
        end
    endtask

    task automatic test_read_errors();
        int beats, lb, bd; bit d, e; logic [31:0] a; logic [7:0] l;
        run_read(32'h0000_0200, 9'd8, 5, 0, 32'h1000_0000, beats, lb, bd, d, e, a, l);
        tests++;
        if (beats !== 5 || lb !== 5 || bd !== 0) begin
            fails++; $display("FAIL rd_early_last_beats: got beats=%0d lastbeat=%0d baddata=%0d want 5 5 0", beats, lb, bd);
        end
        tests++;
        if (d !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL rd_early_last_done: got done=%b err=%b want 1 1", d, e);
        end
        run_read(32'h0000_0300, 9'd4, 4, 2, 32'h2000_0000, beats, lb, bd, d, e, a, l);
        tests++;
        if (beats !== 4 || d !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL rd_slverr: got beats=%0d done=%b err=%b want 4 1 1", beats, d, e);
        end
    endtask

    task automatic test_bresp();
        int beats, bl, bd, bh; bit d, e; logic [31:0] a; logic [7:0] l;
        run_write(32'h0000_0040, 9'd2, 1'b0, 2'b10, 4'h0, beats, bl, bd, bh, d, e, a, l);
        tests++;
        if (d !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL bresp_slverr: got done=%b err=%b want 1 1", d, e);
        end
        run_write(32'h0000_0080, 9'd2, 1'b0, 2'b00, 4'h3, beats, bl, bd, bh, d, e, a, l);
        tests++;
        if (d !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL bresp_id: got done=%b err=%b want 1 1", d, e);
        end
    endtask

    task automatic test_timeout();
        int cnt; bit d, e;
        cnt = 0; d = 0; e = 0;
        issue_cmd(1'b1, 32'h0000_0500, 9'd2);
        for (int cyc = 0; cyc < 100 && !d; cyc++) begin
            #1;
            if (bus.MASTER_WR_ADDR_VALID) cnt++;
            if (bus.done) begin d = 1; e = bus.err; end
            @(negedge clk);
        end
        tests++;
        if (cnt !== 16) begin
            fails++; $display("FAIL timeout_valid_cycles: got %0d want 16", cnt);
        end
        tests++;
        if (d !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL timeout_done: got done=%b err=%b want 1 1", d, e);
        end
    endtask

    task automatic test_bad_len();
        int act; bit d, e;
        for (int k = 0; k < 2; k++) begin
            act = 0; d = 0; e = 0;
            bus.MASTER_WR_ADDR_READY = 1; bus.MASTER_RD_ADDR_READY = 1;
            issue_cmd(k == 0, 32'h0000_0600, (k == 0) ? 9'd0 : 9'd257);
            for (int cyc = 0; cyc < 4; cyc++) begin
                #1;
                if (bus.MASTER_WR_ADDR_VALID || bus.MASTER_RD_ADDR_VALID || bus.MASTER_WR_DATA_VALID) act++;
                if (cyc == 0) begin d = bus.done; e = bus.err; end
                @(negedge clk);
            end
            tests++;
            if (act !== 0 || d !== 1'b1 || e !== 1'b1) begin
                fails++; $display("FAIL bad_len_%0d: got activity=%0d done=%b err=%b want 0 1 1", k, act, d, e);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        int dones;
        dones = 0;
        issue_cmd(1'b1, 32'h0000_0700, 9'd8);
        bus.MASTER_WR_ADDR_READY = 1; bus.MASTER_WR_DATA_READY = 1;
        bus.wr_valid = 1; bus.wr_data = 32'h5555_AAAA; bus.wr_strb = 4'hF;
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (bus.MASTER_WR_DATA_VALID !== 1'b1) begin
            fails++; $display("FAIL mid_burst_active: got wvalid=%b want 1", bus.MASTER_WR_DATA_VALID);
        end
        #1 rst = 1;
        #1;
        tests++;
        if ({bus.MASTER_WR_ADDR_VALID, bus.MASTER_WR_DATA_VALID, bus.MASTER_RD_ADDR_VALID,
             bus.wr_ready, bus.MASTER_WR_BACK_READY, bus.done} !== 6'b0) begin
            fails++; $display("FAIL async_reset_valids: got awv=%b wv=%b arv=%b wrdy=%b done=%b want 0",
                              bus.MASTER_WR_ADDR_VALID, bus.MASTER_WR_DATA_VALID,
                              bus.MASTER_RD_ADDR_VALID, bus.wr_ready, bus.done);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        clear_inputs();
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            if (bus.done) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones !== 0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_no_done: got dones=%0d cmd_ready=%b want 0 1", dones, bus.cmd_ready);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write4();
        test_read1();
        test_write256_gaps();
        test_read_errors();
        test_bresp();
        test_timeout();
        test_bad_len();
        test_reset_mid_burst();
        test_write4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_axi_burst_master.md
Name: ddr_axi_burst_master

Overview:
- Initiator side of the DDR slave AXI-style port (WR_ADDR/WR_DATA/WR_BACK/RD_ADDR/RD_BACK channels).
- Turns single user commands (write or read, base address, beat count) into one INCR burst.
- Streams write data in and read data out, then reports completion and error status.
- Sits between lab-logic producers/consumers and the DDR3 controller slave port, on the slave's clock.

Parameters:
- ID_VAL, 4'h0: ID driven on WR_ADDR_ID/RD_ADDR_ID; response IDs must match.
- TIMEOUT_CYC, 4096: cycles without handshake progress before abort with error.
- CNT_W, 9: beat counter width (covers 1..256).

Ports:
- clk  in  1  slave clock (DDR_SLAVE_CLK domain).
- rst  in  1  asynchronous, active-high reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  32  byte address; [1:0] forced to 0 on issue.
- cmd_len  in  9  beats, 1..256; 0 or >256 rejected.
- wr_data/wr_strb  in  32/4  user write beat.
- wr_valid/wr_ready  in/out  1/1  user write stream handshake.
- rd_data  out  32  user read beat.
- rd_last  out  1  marks final read beat.
- rd_valid/rd_ready  out/in  1/1  user read stream handshake.
- done  out  1  one-cycle pulse at command end.
- err  out  1  valid with done: bad response, ID mismatch, LAST misalignment, timeout, or rejected length.
- MASTER_WR_ADDR_ID/ADDR/LEN/BURST  out  4/32/8/2  AW payload; BURST=2'b01, LEN=cmd_len-1.
- MASTER_WR_ADDR_VALID/READY  out/in  1/1.
- MASTER_WR_DATA/STRB/DATA_LAST  out  32/4/1  W payload.
- MASTER_WR_DATA_VALID/READY  out/in  1/1.
- MASTER_WR_BACK_ID/RESP  in  4/2.
- MASTER_WR_BACK_VALID/READY  in/out  1/1.
- MASTER_RD_ADDR_ID/ADDR/LEN/BURST  out  4/32/8/2.
- MASTER_RD_ADDR_VALID/READY  out/in  1/1.
- MASTER_RD_BACK_ID/DATA/DATA_RESP/DATA_LAST  in  4/32/2/1.
- MASTER_RD_DATA_VALID/READY  in/out  1/1.

Behaviour:
- Reset (async, active-high): FSM to IDLE; every output 0 except MASTER_*_BURST=2'b01 and *_ADDR_ID=ID_VAL; beat and timeout counters cleared. A reset mid-burst abandons the burst with no done pulse.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/len/write.
  - len invalid: go to FINISH with err=1.
  - otherwise go to WR_ADDR or RD_ADDR.
- Issue latency: *_ADDR_VALID is asserted the cycle after acceptance and held with stable payload until READY is sampled high.
- WR_DATA:
  - MASTER_WR_DATA_VALID = wr_valid; wr_ready = MASTER_WR_DATA_READY (combinational pass-through; data/strb pass through).
  - Beat counter increments on each W handshake.
  - DATA_LAST=1 exactly on beat cmd_len; the transfer of that beat moves to WR_RESP.
- WR_RESP: BACK_READY=1. On BACK_VALID, err is set if RESP!=2'b00 or ID!=ID_VAL; then FINISH.
- RD_DATA:
  - rd_valid = RD_DATA_VALID; RD_DATA_READY = rd_ready; rd_data passes through.
  - rd_last = RD_DATA_LAST.
  - Every beat with RESP!=0 or ID mismatch sticks err.
  - LAST on a beat other than cmd_len, or no LAST on beat cmd_len, sets err.
  - Burst ends on the LAST handshake or on the counted final beat, whichever comes first.
- FINISH: done=1 for one cycle with accumulated err; then IDLE. Back-to-back command throughput: one command per (burst + 3) cycles minimum.
- Timeout:
  - The counter resets on any handshake on the active channel and increments otherwise outside IDLE/FINISH.
  - At TIMEOUT_CYC the block drops all VALIDs, asserts err, and goes to FINISH.
  - Outstanding slave beats after a timeout are not drained.
- Simultaneous events: READY arriving in the same cycle VALID rises counts as a handshake. A timeout coinciding with a handshake gives the handshake priority.

Decomposition:
- Package ddr_axi_pkg holds:
  - state enum;
  - BURST_INCR=2'b01;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - MAX_BEATS=256.
- Sub-module ddr_axi_wdog: the loadable timeout counter with clear, enable and expire.

Test Plan:
- Write cmd addr=0x0000_1003, len=4, data 0xA0..A3, slave READY always 1 -> AW ADDR=0x0000_1000, LEN=3; LAST on beat 4; done with err=0.
- Read cmd addr=0x100, len=1, slave returns 0xDEADBEEF with LAST -> rd_data=0xDEADBEEF, rd_last=1; done, err=0.
- Write len=256 with random slave READY and user wr_valid gaps -> exactly 256 W beats; LAST only on beat 256; no payload change while VALID & !READY.
- Read len=8, slave asserts LAST on beat 5 -> done after beat 5 with err=1.
- WR_BACK RESP=2'b10, or BACK_ID=4'h3 with ID_VAL=0 -> done with err=1.
- Slave never raises AW READY, TIMEOUT_CYC=16 -> VALID drops after 16 cycles; done with err=1.
- cmd_len=0 -> no AXI activity; done with err=1.
- rst asserted mid-W-burst -> all VALIDs 0 asynchronously; IDLE; no done pulse.
